// File: rtl/fifo_async_write_ptr.sv
// Asynchronous FIFO write-side pointer block: binary/Gray write pointers,
// RAM write address, FULL, ALMOST_FULL and write-side level. Optional macro:
// FIFO_WPTR_OVERFLOW_EN adds a sticky OVERFLOW output.

module gray2bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end
endmodule

module fifo_async_write_ptr #(
    parameter int unsigned PTR_WIDTH   = 4,
    parameter int unsigned AFULL_LEVEL = 6
) (
    input  logic                 WCLK,
    input  logic                 RST,
    input  logic                 WEN,
    input  logic [PTR_WIDTH-1:0] RPTR_G_SYNC,
    output logic [PTR_WIDTH-1:0] WPTR_B,
    output logic [PTR_WIDTH-1:0] WPTR_G,
    output logic [PTR_WIDTH-2:0] WADDR,
    output logic                 FULL,
    output logic                 ALMOST_FULL,
    output logic [PTR_WIDTH-1:0] WLEVEL
`ifdef FIFO_WPTR_OVERFLOW_EN
    ,
    output logic                 OVERFLOW
`endif
);
    // Full when the write pointer equals the read pointer with its top two
    // Gray bits inverted; built as a mask so PTR_WIDTH=2 needs no empty slice.
    localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(3) << (PTR_WIDTH - 2);
    localparam logic [PTR_WIDTH-1:0] AFULL_THR = PTR_WIDTH'(AFULL_LEVEL);

    logic [PTR_WIDTH-1:0] rptr_b_sync;
    logic                 wacc;

    logic [PTR_WIDTH-1:0] wptr_b_q, wptr_b_d;
    logic [PTR_WIDTH-1:0] wptr_g_q, wptr_g_d;
    logic [PTR_WIDTH-1:0] level_q,  level_d;
    logic                 full_q,   full_d;
    logic                 afull_q,  afull_d;

    gray2bin #(
        .WIDTH(PTR_WIDTH)
    ) u_rptr_g2b (
        .gray(RPTR_G_SYNC),
        .bin (rptr_b_sync)
    );

    always_comb begin
        wacc     = WEN & ~full_q;
        wptr_b_d = wptr_b_q + PTR_WIDTH'(wacc);
        wptr_g_d = (wptr_b_d >> 1) ^ wptr_b_d;
        level_d  = wptr_b_d - rptr_b_sync;
        full_d   = (wptr_g_d == (RPTR_G_SYNC ^ FULL_MASK));
        afull_d  = (level_d >= AFULL_THR);
    end

    always_ff @(posedge WCLK) begin
        if (RST) begin
            wptr_b_q <= '0;
            wptr_g_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wptr_b_q <= wptr_b_d;
            wptr_g_q <= wptr_g_d;
            level_q  <= level_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
        end
    end

`ifdef FIFO_WPTR_OVERFLOW_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | (WEN & full_q);
    end

    always_ff @(posedge WCLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVERFLOW = ovf_q;
`endif

    assign WPTR_B      = wptr_b_q;
    assign WPTR_G      = wptr_g_q;
    assign WADDR       = wptr_b_q[PTR_WIDTH-2:0];
    assign FULL        = full_q;
    assign ALMOST_FULL = afull_q;
    assign WLEVEL      = level_q;

endmodule

// File: tb/tb_fifo_async_write_ptr.sv
// Self-checking bench for fifo_async_write_ptr (PTR_WIDTH=4, depth 8), with a
// counting FIFO model; OVERFLOW checked when FIFO_WPTR_OVERFLOW_EN is defined.

module tb_fifo_async_write_ptr;
    logic       WCLK;
    logic       RST;
    logic       WEN;
    logic [3:0] RPTR_G_SYNC;
    logic [3:0] WPTR_B;
    logic [3:0] WPTR_G;
    logic [2:0] WADDR;
    logic       FULL;
    logic       ALMOST_FULL;
    logic [3:0] WLEVEL;
`ifdef FIFO_WPTR_OVERFLOW_EN
    logic       OVERFLOW;
`endif

    fifo_async_write_ptr #(
        .PTR_WIDTH  (4),
        .AFULL_LEVEL(6)
    ) dut (
        .WCLK       (WCLK),
        .RST        (RST),
        .WEN        (WEN),
        .RPTR_G_SYNC(RPTR_G_SYNC),
        .WPTR_B     (WPTR_B),
        .WPTR_G     (WPTR_G),
        .WADDR      (WADDR),
        .FULL       (FULL),
        .ALMOST_FULL(ALMOST_FULL),
        .WLEVEL     (WLEVEL)
`ifdef FIFO_WPTR_OVERFLOW_EN
        ,
        .OVERFLOW   (OVERFLOW)
`endif
    );

    initial WCLK = 1'b0;
    always #5 WCLK = ~WCLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model: pointers as plain counters modulo 16, fill = writes minus reads.
    int m_wptr  = 0;
    int m_rptr  = 0;
    int m_level = 0;
    bit m_full  = 0;
    bit m_afull = 0;
    bit m_ovf   = 0;

    function automatic logic [3:0] to_gray(input int b);
        int v;
        v = b % 16;
        return 4'(v ^ (v >> 1));
    endfunction

    task automatic cycle(input bit wen, input bit rst);
        bit acc;
        WEN         = wen;
        RST         = rst;
        RPTR_G_SYNC = to_gray(m_rptr);
        @(posedge WCLK);
        #1;
        if (rst) begin
            m_wptr = 0; m_rptr = 0; m_level = 0;
            m_full = 0; m_afull = 0; m_ovf = 0;
        end else begin
            acc     = wen && !m_full;
            m_ovf   = m_ovf | (wen && m_full);
            m_wptr  = (m_wptr + int'(acc)) % 16;
            m_level = (m_wptr - m_rptr + 16) % 16;
            m_full  = (m_level == 8);
            m_afull = (m_level >= 6);
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        total_cnt++;
        if ({WPTR_B, WPTR_G, WADDR, WLEVEL, FULL, ALMOST_FULL} !== 17'd0)
            $display("FAIL reset_outputs: got %h/%h/%h/%h/%b/%b want all 0",
                     WPTR_B, WPTR_G, WADDR, WLEVEL, FULL, ALMOST_FULL);
        else pass_cnt++;
`ifdef FIFO_WPTR_OVERFLOW_EN
        total_cnt++;
        if (OVERFLOW !== 1'b0) $display("FAIL reset_ovf: got %b want 0", OVERFLOW);
        else pass_cnt++;
`endif
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0);
            total_cnt++;
            if (WPTR_B !== 4'(i + 1)) $display("FAIL fill_wptr_b: got %0d want %0d", WPTR_B, i + 1);
            else pass_cnt++;
            total_cnt++;
            if (FULL !== m_full) $display("FAIL fill_full: got %b want %b", FULL, m_full);
            else pass_cnt++;
        end
        total_cnt++;
        if ({FULL, WPTR_G, WLEVEL, WADDR} !== {1'b1, 4'b1100, 4'd8, 3'd0})
            $display("FAIL fill_end: got full=%b g=%b lvl=%0d addr=%0d want 1/1100/8/0",
                     FULL, WPTR_G, WLEVEL, WADDR);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            total_cnt++;
            if (WPTR_B !== 4'd8 || WLEVEL !== 4'd8 || FULL !== 1'b1)
                $display("FAIL ovf_hold: got b=%0d lvl=%0d full=%b want 8/8/1", WPTR_B, WLEVEL, FULL);
            else pass_cnt++;
`ifdef FIFO_WPTR_OVERFLOW_EN
            total_cnt++;
            if (OVERFLOW !== 1'b1) $display("FAIL ovf_flag: got %b want 1", OVERFLOW);
            else pass_cnt++;
`endif
        end
    endtask

    task automatic test_drain();
        m_rptr = 3;
        cycle(1'b0, 1'b0);
        total_cnt++;
        if (RPTR_G_SYNC !== 4'b0010) $display("FAIL drain_drive: got %b want 0010", RPTR_G_SYNC);
        else pass_cnt++;
        total_cnt++;
        if ({FULL, WLEVEL, ALMOST_FULL} !== {1'b0, 4'd5, 1'b0})
            $display("FAIL drain: got full=%b lvl=%0d af=%b want 0/5/0", FULL, WLEVEL, ALMOST_FULL);
        else pass_cnt++;
    endtask

    task automatic test_almost_full();
        cycle(1'b1, 1'b0);
        total_cnt++;
        if ({WPTR_B, WLEVEL, ALMOST_FULL} !== {4'd9, 4'd6, 1'b1})
            $display("FAIL afull: got b=%0d lvl=%0d af=%b want 9/6/1", WPTR_B, WLEVEL, ALMOST_FULL);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [3:0] prev_g;
        logic [2:0] prev_a;
        int         addr_wraps;
        bit         saw_g_wrap;
        addr_wraps = 0;
        saw_g_wrap = 0;
        for (int i = 0; i < 20; i++) begin
            prev_g = WPTR_G;
            prev_a = WADDR;
            m_rptr = (m_wptr - 2 + 16) % 16;
            cycle(1'b1, 1'b0);
            if (prev_a == 3'd7 && WADDR == 3'd0) addr_wraps++;
            if (prev_g == 4'b1000 && WPTR_G == 4'b0000) saw_g_wrap = 1;
            total_cnt++;
            if ($countones(prev_g ^ WPTR_G) != 1)
                $display("FAIL wrap_gray_step: %b -> %b", prev_g, WPTR_G);
            else pass_cnt++;
            total_cnt++;
            if (WPTR_B !== 4'(m_wptr) || FULL !== 1'b0 || WLEVEL !== 4'd3)
                $display("FAIL wrap_state: got b=%0d full=%b lvl=%0d want %0d/0/3",
                         WPTR_B, FULL, WLEVEL, m_wptr);
            else pass_cnt++;
        end
        total_cnt++;
        if (addr_wraps != 2 || !saw_g_wrap)
            $display("FAIL wrap_counts: addr_wraps=%0d gray_wrap=%b want 2/1", addr_wraps, saw_g_wrap);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] held;
        for (int i = 0; i < 10 && !m_full; i++) cycle(1'b1, 1'b0);
        total_cnt++;
        if (FULL !== 1'b1) $display("FAIL b2b_reach_full: got %b want 1 (budget)", FULL);
        else pass_cnt++;
        held   = WPTR_B;
        m_rptr = (m_rptr + 1) % 16;
        cycle(1'b1, 1'b0);
        total_cnt++;
        if (WPTR_B !== held || FULL !== 1'b0 || WLEVEL !== 4'd7)
            $display("FAIL b2b_release: got b=%0d full=%b lvl=%0d want %0d/0/7", WPTR_B, FULL, WLEVEL, held);
        else pass_cnt++;
        cycle(1'b1, 1'b0);
        total_cnt++;
        if (WPTR_B !== held + 4'd1 || FULL !== 1'b1)
            $display("FAIL b2b_accept: got b=%0d full=%b want %0d/1", WPTR_B, FULL, held + 4'd1);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit wen;
        for (int i = 0; i < 300; i++) begin
            wen = ($urandom_range(0, 9) < 6);
            if (((m_wptr - m_rptr + 16) % 16) > 0 && $urandom_range(0, 2) == 0)
                m_rptr = (m_rptr + 1) % 16;
            cycle(wen, 1'b0);
            total_cnt++;
            if (WPTR_B !== 4'(m_wptr) || WPTR_G !== to_gray(m_wptr) || WADDR !== 3'(m_wptr % 8))
                $display("FAIL rnd_ptr: got b=%0d g=%b a=%0d want b=%0d", WPTR_B, WPTR_G, WADDR, m_wptr);
            else pass_cnt++;
            total_cnt++;
            if (WLEVEL !== 4'(m_level) || FULL !== m_full || ALMOST_FULL !== m_afull)
                $display("FAIL rnd_flags: got lvl=%0d full=%b af=%b want %0d/%b/%b",
                         WLEVEL, FULL, ALMOST_FULL, m_level, m_full, m_afull);
            else pass_cnt++;
`ifdef FIFO_WPTR_OVERFLOW_EN
            total_cnt++;
            if (OVERFLOW !== m_ovf) $display("FAIL rnd_ovf: got %b want %b", OVERFLOW, m_ovf);
            else pass_cnt++;
`endif
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
        total_cnt++;
        if (WPTR_B !== 4'd5) $display("FAIL rmid_setup: got %0d want 5", WPTR_B);
        else pass_cnt++;
        cycle(1'b1, 1'b1);
        total_cnt++;
        if ({WPTR_B, WPTR_G, WADDR, WLEVEL, FULL, ALMOST_FULL} !== 17'd0)
            $display("FAIL rmid_clear: got %h/%h/%h/%h/%b/%b want all 0",
                     WPTR_B, WPTR_G, WADDR, WLEVEL, FULL, ALMOST_FULL);
        else pass_cnt++;
`ifdef FIFO_WPTR_OVERFLOW_EN
        total_cnt++;
        if (OVERFLOW !== 1'b0) $display("FAIL rmid_ovf: got %b want 0", OVERFLOW);
        else pass_cnt++;
`endif
        cycle(1'b1, 1'b0);
        total_cnt++;
        if (WPTR_B !== 4'd1 || WLEVEL !== 4'd1)
            $display("FAIL rmid_first_write: got b=%0d lvl=%0d want 1/1", WPTR_B, WLEVEL);
        else pass_cnt++;
    endtask

    initial begin
        RST         = 1'b1;
        WEN         = 1'b0;
        RPTR_G_SYNC = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_almost_full();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
